instruction_queue: RTL and testbench
====================================

// Module: instruction_queue
// PURPOSE
//  Parametrised successor to the single-entry instruction register: a DEPTH-entry
//  FIFO of fetched MIPS-format instructions, each tagged with its PC.
//  Sits between instruction memory/fetch and the decode stage. Uses valid/ready
//  handshakes on both sides and supports a synchronous flush for branches/jumps.
//  Presents the head entry pre-split into R/I/J fields plus format flags.
// PARAMETERS
//  INSTR_W  32  instruction width; field slicing below assumes 32
//  PC_W     32  width of the PC tag stored with each instruction
//  DEPTH     4  queue entries; power of two, >= 2
//  PTR_W     2  $clog2(DEPTH); derived, not overridden
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  flush       in   1        synchronous discard of all entries
//  in_valid    in   1        fetch offers {in_pc, in_instr}
//  in_ready    out  1        queue accepts; equals !full
//  in_instr    in   INSTR_W  fetched instruction word
//  in_pc       in   PC_W     PC of in_instr
//  out_valid   out  1        head entry valid; equals !empty
//  out_ready   in   1        decode consumes head this cycle
//  out_instr   out  INSTR_W  head instruction word
//  out_pc      out  PC_W     head PC tag
//  opcode      out  6        out_instr[31:26]
//  rs/rt/rd    out  5 each   [25:21] / [20:16] / [15:11]
//  shamt       out  5        [10:6]
//  funct       out  6        [5:0]
//  immediate   out  16       [15:0]
//  target      out  26       [25:0]
//  is_rtype    out  1        opcode==6'h00
//  is_jtype    out  1        opcode==6'h02 or 6'h03
//  count       out  PTR_W+1  number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n low, async): rd/wr pointers=0, count=0, storage cleared to 0;
//    out_valid=0, in_ready=1, all field outputs 0, is_rtype=1 (opcode 0).
//  - Push on in_valid&&in_ready; pop on out_valid&&out_ready; both at posedge clk.
//  - in_ready depends on state only (!full); no combinational path from out_ready.
//  - No bypass: a push into an empty queue is visible at the output the next
//    cycle, so latency from push to out_valid is 1 cycle.
//  - Simultaneous push+pop with 0<count<DEPTH: count unchanged, both pointers
//    advance. When full, in_ready=0, so only the pop takes effect. When empty,
//    out_valid=0, so only the push takes effect.
//  - Pop while empty and push while full are ignored. No error flag is raised.
//  - Pointers wrap modulo DEPTH. count is kept explicitly; full=(count==DEPTH).
//  - flush=1 has priority: pointers and count go to 0 and any same-cycle push
//    or pop is dropped. Storage contents are not cleared, but the field outputs
//    are qualified by out_valid in the bench only.
//  - Field outputs are combinational slices of the head storage word, which
//    mirrors the original IR decode, with out_valid as the qualifier.
//  - Reset asserted mid-stream discards all entries immediately, without
//    waiting for a clock edge.
// STRUCTURE
//  - Package instr_pkg: field bit positions (OP_HI/LO, RS_HI/LO, ...) and the
//    constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03.
//  - Sub-module instr_field_decode: pure combinational split of one word into
//    the fields and format flags. It will be reused by later pipeline stages.
//  - The queue core is a register-array FIFO. No RAM macro is used.
// TESTING
//  1 Reset: rst_n=0 -> count=0, out_valid=0, in_ready=1, opcode=0, target=0.
//  2 Push 0x012A4020 (add $8,$9,$10) at pc 0x400 -> next cycle out_valid=1,
//    rs=9, rt=10, rd=8, funct=0x20, is_rtype=1, out_pc=0x400.
//  3 Push 4 words with out_ready=0 -> count=4, in_ready=0; a 5th push is
//    ignored; pops then return words in order and count goes 3,2,1,0.
//  4 With count=2, hold in_valid=out_ready=1 for 10 cycles -> count stays 2,
//    pointers wrap, and output order equals input order.
//  5 Push 0x0C100000 (jal) -> is_jtype=1, target=0x0100000. Flush together
//    with a push -> next cycle count=0, out_valid=0.
//  6 Drop rst_n between clocks while count=3 -> count=0 and out_valid=0 at
//    once; after rst_n rises, the first push is accepted normally.

Source files
------------

// File: rtl/instr_pkg.sv
// ----------------------------------------------------------------------------
// instr_pkg
// Purpose : Shared MIPS instruction-format definitions.
//           - bit positions of the R/I/J fields within a 32-bit word
//           - the opcode constants used to classify the instruction format
//           - a small helper that classifies an opcode as a J-format jump
// Ports   : none (package)
// ----------------------------------------------------------------------------
package instr_pkg;

  // Field bit positions within a 32-bit MIPS instruction word
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // Opcode constants
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // J-format covers both the plain jump and jump-and-link
  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// ----------------------------------------------------------------------------
// instr_field_decode
// Purpose : Pure combinational split of one 32-bit MIPS instruction word into
//           its R/I/J fields plus format flags. Intended for reuse by later
//           pipeline stages, so it holds no state and no qualifier logic.
// Ports   :
//   instr      in   32  instruction word
//   opcode     out  6   [31:26]
//   rs/rt/rd   out  5   [25:21] / [20:16] / [15:11]
//   shamt      out  5   [10:6]
//   funct      out  6   [5:0]
//   immediate  out  16  [15:0]
//   target     out  26  [25:0]
//   is_rtype   out  1   opcode == OP_RTYPE
//   is_jtype   out  1   opcode == OP_J or OP_JAL
// ----------------------------------------------------------------------------
module instr_field_decode
  import instr_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] immediate,
  output logic [25:0] target,
  output logic        is_rtype,
  output logic        is_jtype
);

  assign opcode    = instr[OP_HI:OP_LO];
  assign rs        = instr[RS_HI:RS_LO];
  assign rt        = instr[RT_HI:RT_LO];
  assign rd        = instr[RD_HI:RD_LO];
  assign shamt     = instr[SH_HI:SH_LO];
  assign funct     = instr[FN_HI:FN_LO];
  assign immediate = instr[IMM_HI:IMM_LO];
  assign target    = instr[TGT_HI:TGT_LO];

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jtype  = is_jump_op(opcode);

endmodule

// File: rtl/instruction_queue.sv
// ----------------------------------------------------------------------------
// instruction_queue
// Purpose : DEPTH-entry FIFO of fetched MIPS instructions, each tagged with its
//           PC, between fetch and decode. valid/ready on both sides, synchronous
//           flush (for redirects) with priority over push/pop. The head entry is
//           presented pre-split into R/I/J fields and format flags.
// Ports   :
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   flush      in   1        synchronous discard of all entries
//   in_valid   in   1        fetch offers {in_pc, in_instr}
//   in_ready   out  1        !full (state only, no path from out_ready)
//   in_instr   in   INSTR_W  fetched instruction word
//   in_pc      in   PC_W     PC of in_instr
//   out_valid  out  1        !empty
//   out_ready  in   1        decode consumes head this cycle
//   out_instr  out  INSTR_W  head instruction word
//   out_pc     out  PC_W     head PC tag
//   opcode..target, is_rtype, is_jtype : combinational fields of head word
//   count      out  PTR_W+1  number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module instruction_queue
  import instr_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                immediate,
  output logic [25:0]                target,
  output logic                       is_rtype,
  output logic                       is_jtype,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] instr_mem_reg [DEPTH];
  logic [PC_W-1:0]    pc_mem_reg    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg,  count_next;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full      = (count_reg == CNT_DEPTH);
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_reg;

  // Flush suppresses both handshakes so neither pointer nor storage moves
  assign push = in_valid  && !full  && !flush;
  assign pop  = out_ready && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One register slot per entry; only the slot under the write pointer loads.
  // Flush leaves contents intact since the pointers alone define validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        instr_mem_reg[gi] <= '0;
        pc_mem_reg[gi]    <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        instr_mem_reg[gi] <= in_instr;
        pc_mem_reg[gi]    <= in_pc;
      end
    end
  end

  // No bypass: the head is always read from storage
  assign out_instr = instr_mem_reg[rd_ptr_reg];
  assign out_pc    = pc_mem_reg[rd_ptr_reg];

  instr_field_decode u_decode (
    .instr     (out_instr[31:0]),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .immediate (immediate),
    .target    (target),
    .is_rtype  (is_rtype),
    .is_jtype  (is_jtype)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// ----------------------------------------------------------------------------
// tb_instruction_queue
// Directed test of instruction_queue (DEPTH=4): reset values, R-type decode,
// fill/overflow/drain ordering, streaming with pointer wrap, J-type decode,
// flush priority, and asynchronous reset mid-stream.
// ----------------------------------------------------------------------------
module tb_instruction_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] target;
  logic        is_rtype, is_jtype;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .immediate (immediate),
    .target    (target),
    .is_rtype  (is_rtype),
    .is_jtype  (is_jtype),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
      $display("[TB] check %s ok: %0h", tag, obs);
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // 1: reset state
    #3;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_opcode",    64'(opcode),    64'd0);
    chk("rst_target",    64'(target),    64'd0);
    chk("rst_is_rtype",  64'(is_rtype),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2: R-type add $8,$9,$10
    in_valid = 1'b1; in_instr = 32'h012A4020; in_pc = 32'h400;
    chk("pre_push_out_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    chk("add_out_valid", 64'(out_valid), 64'd1);
    chk("add_rs",        64'(rs),        64'd9);
    chk("add_rt",        64'(rt),        64'd10);
    chk("add_rd",        64'(rd),        64'd8);
    chk("add_funct",     64'(funct),     64'h20);
    chk("add_shamt",     64'(shamt),     64'd0);
    chk("add_is_rtype",  64'(is_rtype),  64'd1);
    chk("add_is_jtype",  64'(is_jtype),  64'd0);
    chk("add_out_pc",    64'(out_pc),    64'h400);
    chk("add_count",     64'(count),     64'd1);
    out_ready = 1'b1;
    step();
    chk("add_pop_count", 64'(count), 64'd0);
    chk("add_pop_valid", 64'(out_valid), 64'd0);
    // pop while empty is ignored
    step();
    chk("empty_pop_count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 3: fill, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h1000_0000 + 32'(i); in_pc = 32'h500 + 32'(4*i);
      step();
    end
    chk("fill_count",    64'(count),    64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'hDEADBEEF; in_pc = 32'hBAD;
    step();
    in_valid = 1'b0;
    chk("overflow_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_instr%0d", i), 64'(out_instr), 64'(32'h1000_0000 + 32'(i)));
      chk($sformatf("drain_pc%0d", i),    64'(out_pc),    64'(32'h500 + 32'(4*i)));
      step();
      chk($sformatf("drain_count%0d", i), 64'(count), 64'(3 - i));
    end
    out_ready = 1'b0;
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // 4: streaming with count=2, pointers wrap
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'hA000_0000 + 32'(i); in_pc = 32'h700 + 32'(i);
      step();
    end
    chk("stream_pre_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr = 32'hA000_0000 + 32'(k + 2); in_pc = 32'h700 + 32'(k + 2);
      chk($sformatf("stream_out%0d", k), 64'(out_instr), 64'(32'hA000_0000 + 32'(k)));
      step();
      chk($sformatf("stream_count%0d", k), 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      chk($sformatf("stream_tail%0d", k), 64'(out_instr), 64'(32'hA000_0000 + 32'(k)));
      chk($sformatf("stream_tail_pc%0d", k), 64'(out_pc), 64'(32'h700 + 32'(k)));
      step();
    end
    out_ready = 1'b0;
    chk("stream_end_count", 64'(count), 64'd0);

    // 5: J-type jal, then flush with a simultaneous push
    in_valid = 1'b1; in_instr = 32'h0C100000; in_pc = 32'h800;
    step();
    in_valid = 1'b0;
    chk("jal_is_jtype", 64'(is_jtype), 64'd1);
    chk("jal_is_rtype", 64'(is_rtype), 64'd0);
    chk("jal_opcode",   64'(opcode),   64'h03);
    chk("jal_target",   64'(target),   64'h0100000);
    chk("jal_imm",      64'(immediate), 64'h0000);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h08000010; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'hC000_0000 + 32'(i); in_pc = 32'h900 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count",     64'(count),     64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    #1;
    rst_n = 1'b1;
    step();
    w = 32'h20080005;
    in_valid = 1'b1; in_instr = w; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    chk("post_rst_out_valid", 64'(out_valid), 64'd1);
    chk("post_rst_instr",     64'(out_instr), 64'(w));
    chk("post_rst_pc",        64'(out_pc),    64'h600);
    chk("post_rst_count",     64'(count),     64'd1);
    chk("post_rst_imm",       64'(immediate), 64'h0005);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
